// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable raster timing generator with frame-boundary shadow config
module video_timing_gen #(
    parameter int   CW         = 12,
    parameter logic H_POLARITY = 1'b1,
    parameter logic V_POLARITY = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          pix_ce,
    input  logic [CW-1:0] cfg_h_total,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_sync_start,
    input  logic [CW-1:0] cfg_h_sync_end,
    input  logic [CW-1:0] cfg_v_total,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_sync_start,
    input  logic [CW-1:0] cfg_v_sync_end,
    output logic          hs,
    output logic          vs,
    output logic          active_video,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          cfg_err
);

    typedef enum logic {S_HALT, S_RUN} state_t;

    state_t        state_q, state_d;
    logic          first_q, first_d;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [CW-1:0] ht_q, ht_d, ha_q, ha_d, hss_q, hss_d, hse_q, hse_d;
    logic [CW-1:0] vt_q, vt_d, va_q, va_d, vss_q, vss_d, vse_q, vse_d;
    logic          hs_q, hs_d, vs_q, vs_d, av_q, av_d;
    logic          ls_q, ls_d, fs_q, fs_d, err_q, err_d;
    logic          cfg_in_ok;

    function automatic logic cfg_valid(
        input logic [CW-1:0] ht, ha, hss, hse, vt, va, vss, vse
    );
        return (ht >= CW'(2)) && (vt >= CW'(1)) && (ha <= ht) && (va <= vt) &&
               (hss < hse) && (hse <= ht) && (vss < vse) && (vse <= vt);
    endfunction

    assign cfg_in_ok = cfg_valid(cfg_h_total, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end,
                                 cfg_v_total, cfg_v_active, cfg_v_sync_start, cfg_v_sync_end);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= cfg_in_ok ? S_RUN : S_HALT;
            err_q   <= !cfg_in_ok;
            first_q <= 1'b1;
            hc_q    <= '0;
            vc_q    <= '0;
            ht_q    <= cfg_h_total;
            ha_q    <= cfg_h_active;
            hss_q   <= cfg_h_sync_start;
            hse_q   <= cfg_h_sync_end;
            vt_q    <= cfg_v_total;
            va_q    <= cfg_v_active;
            vss_q   <= cfg_v_sync_start;
            vse_q   <= cfg_v_sync_end;
            hs_q    <= !H_POLARITY;
            vs_q    <= !V_POLARITY;
            av_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            first_q <= first_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            ht_q    <= ht_d;
            ha_q    <= ha_d;
            hss_q   <= hss_d;
            hse_q   <= hse_d;
            vt_q    <= vt_d;
            va_q    <= va_d;
            vss_q   <= vss_d;
            vse_q   <= vse_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            av_q    <= av_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        first_d = first_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        ht_d    = ht_q;
        ha_d    = ha_q;
        hss_d   = hss_q;
        hse_d   = hse_q;
        vt_d    = vt_q;
        va_d    = va_q;
        vss_d   = vss_q;
        vse_d   = vse_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        av_d    = av_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;

        if (state_q == S_HALT) begin
            ht_d  = cfg_h_total;
            ha_d  = cfg_h_active;
            hss_d = cfg_h_sync_start;
            hse_d = cfg_h_sync_end;
            vt_d  = cfg_v_total;
            va_d  = cfg_v_active;
            vss_d = cfg_v_sync_start;
            vse_d = cfg_v_sync_end;
            hc_d  = '0;
            vc_d  = '0;
            hs_d  = !H_POLARITY;
            vs_d  = !V_POLARITY;
            av_d  = 1'b0;
            err_d = !cfg_in_ok;
            if (cfg_in_ok) begin
                state_d = S_RUN;
                first_d = 1'b1;
            end
        end else if (pix_ce) begin
            // The first pixel after reset or halt is presented, not stepped past.
            if (first_q) begin
                hc_d    = '0;
                vc_d    = '0;
                first_d = 1'b0;
                ls_d    = 1'b1;
                fs_d    = 1'b1;
            end else if (hc_q == ht_q - CW'(1)) begin
                hc_d = '0;
                ls_d = 1'b1;
                if (vc_q == vt_q - CW'(1)) begin
                    vc_d  = '0;
                    fs_d  = 1'b1;
                    ht_d  = cfg_h_total;
                    ha_d  = cfg_h_active;
                    hss_d = cfg_h_sync_start;
                    hse_d = cfg_h_sync_end;
                    vt_d  = cfg_v_total;
                    va_d  = cfg_v_active;
                    vss_d = cfg_v_sync_start;
                    vse_d = cfg_v_sync_end;
                    if (!cfg_in_ok) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                        ls_d    = 1'b0;
                        fs_d    = 1'b0;
                    end
                end else begin
                    vc_d = vc_q + CW'(1);
                end
            end else begin
                hc_d = hc_q + CW'(1);
            end

            if (state_d == S_RUN) begin
                hs_d = ((hc_d >= hss_d) && (hc_d < hse_d)) ~^ H_POLARITY;
                vs_d = ((vc_d >= vss_d) && (vc_d < vse_d)) ~^ V_POLARITY;
                av_d = (hc_d < ha_d) && (vc_d < va_d);
            end else begin
                hs_d = !H_POLARITY;
                vs_d = !V_POLARITY;
                av_d = 1'b0;
            end
        end
    end

    assign hs           = hs_q;
    assign vs           = vs_q;
    assign active_video = av_q;
    assign x            = hc_q;
    assign y            = vc_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed vector bench for video_timing_gen on a scaled 10x5 raster
module tb_video_timing_gen;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst, ce;
    logic [CW-1:0] ht, ha, hss, hse, vt, va, vss, vse;
    logic          hs0, vs0, av0, ls0, fs0, err0;
    logic [CW-1:0] x0, y0;
    logic          hs1, vs1, av1, ls1, fs1, err1;
    logic [CW-1:0] x1, y1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    video_timing_gen #(.CW(CW), .H_POLARITY(1'b1), .V_POLARITY(1'b1)) u_pos (
        .CLK(clk), .RST(rst), .pix_ce(ce),
        .cfg_h_total(ht), .cfg_h_active(ha), .cfg_h_sync_start(hss), .cfg_h_sync_end(hse),
        .cfg_v_total(vt), .cfg_v_active(va), .cfg_v_sync_start(vss), .cfg_v_sync_end(vse),
        .hs(hs0), .vs(vs0), .active_video(av0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0), .cfg_err(err0)
    );

    video_timing_gen #(.CW(CW), .H_POLARITY(1'b0), .V_POLARITY(1'b0)) u_neg (
        .CLK(clk), .RST(rst), .pix_ce(ce),
        .cfg_h_total(ht), .cfg_h_active(ha), .cfg_h_sync_start(hss), .cfg_h_sync_end(hse),
        .cfg_v_total(vt), .cfg_v_active(va), .cfg_v_sync_start(vss), .cfg_v_sync_end(vse),
        .hs(hs1), .vs(vs1), .active_video(av1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1), .cfg_err(err1)
    );

    typedef struct {
        logic          rst, ce, hs, vs, av;
        logic [CW-1:0] x, y;
        logic          ls, fs, err;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs0();
        return {2'b00, hs0, vs0, av0, x0, y0, ls0, fs0, err0};
    endfunction

    function automatic logic [31:0] mk(input logic h, v, a, input int xx, yy, input logic l, f, e);
        return {2'b00, h, v, a, CW'(xx), CW'(yy), l, f, e};
    endfunction

    function automatic vec_t mkv(input logic r, c, h, v, a, input int xx, yy, input logic l, f, e);
        vec_t t;
        t.rst = r; t.ce = c; t.hs = h; t.vs = v; t.av = a;
        t.x = CW'(xx); t.y = CW'(yy); t.ls = l; t.fs = f; t.err = e;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // what: 0 = line_start, 1 = frame_start, 2 = cfg_err
    task automatic wait_for(input int what, output int n);
        logic hit;
        n = 0;
        do begin
            step();
            n++;
            hit = (what == 0) ? ls0 : (what == 1) ? fs0 : err0;
        end while (!hit && n < 300);
    endtask

    initial begin
        int nhs, nhs1, nvs, nav, nls, nfs, bad, n, fs_first, fs_gap, fs_last;
        logic [31:0] prev;

        rst = 1'b1; ce = 1'b1;
        ht = 10; ha = 6; hss = 7; hse = 9;
        vt = 5;  va = 3; vss = 3; vse = 4;

        tbl[0]  = mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(0, 1, 0, 0, 1, 0, 0, 1, 1, 0);
        tbl[3]  = mkv(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[4]  = mkv(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[5]  = mkv(0, 1, 0, 0, 1, 2, 0, 0, 0, 0);
        tbl[6]  = mkv(0, 1, 0, 0, 1, 3, 0, 0, 0, 0);
        tbl[7]  = mkv(0, 1, 0, 0, 1, 4, 0, 0, 0, 0);
        tbl[8]  = mkv(0, 1, 0, 0, 1, 5, 0, 0, 0, 0);
        tbl[9]  = mkv(0, 1, 0, 0, 0, 6, 0, 0, 0, 0);
        tbl[10] = mkv(0, 1, 1, 0, 0, 7, 0, 0, 0, 0);
        tbl[11] = mkv(0, 1, 1, 0, 0, 8, 0, 0, 0, 0);
        tbl[12] = mkv(0, 1, 0, 0, 0, 9, 0, 0, 0, 0);
        tbl[13] = mkv(0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        tbl[14] = mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mkv(0, 1, 0, 0, 1, 0, 0, 1, 1, 0);

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst;
            ce  = tbl[i].ce;
            step();
            check($sformatf("vec%0d", i), outs0(),
                  mk(tbl[i].hs, tbl[i].vs, tbl[i].av, int'(tbl[i].x), int'(tbl[i].y),
                     tbl[i].ls, tbl[i].fs, tbl[i].err));
            if (i == 0) check("neg_pol_reset", {30'd0, hs1, vs1}, 32'd3);
        end

        // two full frames at pix_ce=1
        ce = 1'b1;
        nhs = 0; nhs1 = 0; nvs = 0; nav = 0; nls = 0; nfs = 0; bad = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (hs0) begin nhs++; if (x0 < 7 || x0 > 8) bad++; end
            if (!hs1) begin nhs1++; if (x1 < 7 || x1 > 8) bad++; end
            if (vs0) begin nvs++; if (y0 != 3) bad++; end
            if (av0) begin nav++; if (x0 >= 6 || y0 >= 3) bad++; end
            if (ls0) begin nls++; if (x0 != 0) bad++; end
            if (fs0) begin nfs++; if (!ls0 || y0 != 0 || (i % 50) != 0) bad++; end
        end
        check("hs_count", nhs, 20);
        check("neg_hs_low_count", nhs1, 20);
        check("vs_count", nvs, 20);
        check("active_count", nav, 36);
        check("line_count", nls, 10);
        check("frame_count", nfs, 2);
        check("position_violations", bad, 0);

        // pix_ce alternating 1/0
        bad = 0; nfs = 0; fs_first = -1; fs_last = -1; fs_gap = 0;
        prev = outs0();
        for (int i = 1; i <= 200; i++) begin
            ce = (i % 2) == 1;
            step();
            if (!ce && outs0() !== (prev & ~32'd6)) bad++;
            if (fs0) begin
                nfs++;
                if (fs_first < 0) fs_first = i; else fs_gap = i - fs_last;
                fs_last = i;
            end
            prev = outs0();
        end
        check("ce_hold_violations", bad, 0);
        check("ce_frame_count", nfs, 2);
        check("ce_first_fs", fs_first, 99);
        check("ce_fs_period", fs_gap, 100);

        // h_total change mid-frame takes effect only after the frame wrap
        ce = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("mid_pos", {8'd0, x0, y0}, {8'd0, 12'd0, 12'd2});
        ht = 9;
        wait_for(1, n);
        check("old_frame_tail", n, 30);
        wait_for(0, n);
        check("new_line_len", n, 9);
        wait_for(1, n);
        check("new_frame_tail", n, 36);

        // invalid sync end at frame wrap halts the generator
        hse = 12;
        wait_for(2, n);
        check("halt_latency", n, 45);
        check("halt_outs", outs0(), mk(0, 0, 0, 0, 0, 0, 0, 1));
        check("neg_halt_levels", {30'd0, hs1, vs1}, 32'd3);
        step();
        step();
        check("halt_hold", outs0(), mk(0, 0, 0, 0, 0, 0, 0, 1));
        ce = 1'b0;
        hse = 9;
        step();
        check("recover_idle", outs0(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        ce = 1'b1;
        step();
        check("recover_start", outs0(), mk(0, 0, 1, 0, 0, 1, 1, 0));

        // invalid config present at reset
        rst = 1'b1;
        hss = 9;
        step();
        check("rst_invalid", outs0(), mk(0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1'b0;
        step();
        check("rst_invalid_hold", outs0(), mk(0, 0, 0, 0, 0, 0, 0, 1));
        hss = 7;
        step();
        check("rst_fix_idle", outs0(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        check("rst_fix_start", outs0(), mk(0, 0, 1, 0, 0, 1, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable raster timing generator: the parametrised successor of the fixed CGA timing source. It produces hsync, vsync, active-video, pixel/line coordinates and frame/line strobes from runtime timing registers. New timing values are adopted only at a frame boundary, so the raster never tears. It drives the sampling/acquisition path and the HDMI output timing, and replaces the fixed-mode generator in benches.

## Interface
- CW, 12: width of all counters, coordinates and cfg inputs.
- H_POLARITY, 1: 1 = hs active-high, 0 = active-low.
- V_POLARITY, 1: 1 = vs active-high, 0 = active-low.

Clock and reset are listed first.
- CLK  in  1  system clock; sole clock domain.
- RST  in  1  reset; synchronous and active-high.
- pix_ce  in  1  pixel enable; the raster advances one pixel on each CLK cycle where pix_ce=1.
- cfg_h_total  in  CW  pixels per line.
- cfg_h_active  in  CW  active pixels per line, starting at hc=0.
- cfg_h_sync_start  in  CW  first hc with hsync asserted.
- cfg_h_sync_end  in  CW  first hc after hsync (exclusive).
- cfg_v_total, cfg_v_active, cfg_v_sync_start, cfg_v_sync_end  in  CW each  vertical equivalents, in lines.
- hs  out  1  horizontal sync, with polarity applied.
- vs  out  1  vertical sync, with polarity applied.
- active_video  out  1  high when hc < h_active and vc < v_active.
- x  out  CW  current hc.
- y  out  CW  current vc.
- line_start  out  1  one-CLK pulse when hc becomes 0.
- frame_start  out  1  one-CLK pulse when (hc,vc) becomes (0,0).
- cfg_err  out  1  the latched config is invalid and the generator is halted.

## Operation
- Shadow registers hold the timing set in use. They load from the cfg_* inputs:
  - on the RST cycle;
  - on every frame wrap;
  - on every CLK cycle while halted.
- cfg valid means all of the following:
  - h_total ≥ 2 and v_total ≥ 1;
  - h_active ≤ h_total and v_active ≤ v_total;
  - sync_start < sync_end ≤ total, for both H and V.
- If the cfg is invalid at a load point:
  - cfg_err=1 and the generator enters HALT;
  - hc=vc=0, and all strobes and active_video are 0;
  - hs/vs are held at their inactive level.
- While in HALT, the inputs are rechecked every CLK cycle. On the first valid cycle, the generator goes to RUN with cfg_err=0. The start at (0,0) takes the next pix_ce and emits line_start and frame_start.
- States: HALT and RUN.
- Counter stepping in RUN, on a pix_ce cycle:
  - hc+1, or hc=0 when hc = h_total−1;
  - on an hc wrap, vc+1, or vc=0 when vc = v_total−1 (frame wrap).
- On a frame wrap where the new cfg is invalid: go to HALT. The last frame completes normally.
- With pix_ce=0, all counters and outputs hold, and both strobes are 0.
- hs asserted when h_sync_start ≤ hc < h_sync_end.
- vs asserted when v_sync_start ≤ vc < v_sync_end (whole lines; vs changes only at hc=0).
- Output level = asserted XNOR POLARITY, so the inactive level is !POLARITY.
- Compares are unsigned CW-bit values. Counters never exceed total−1, so no overflow is possible.
- Changes on cfg_* in the middle of a frame have no effect until the next frame wrap.

## Timing
- All outputs are registered and mutually aligned. x/y and the decoded outputs describe the same pixel and update on the same CLK edge as the counters.
- Reset values: hs=!H_POLARITY, vs=!V_POLARITY, active_video=0, x=y=0, line_start=0, frame_start=0.
- cfg_err=1 after reset if the cfg inputs are invalid at RST, otherwise 0.
- Startup after RST deasserts with a valid cfg:
  - the first pix_ce cycle presents (0,0);
  - that cycle has frame_start=1, line_start=1, and active_video=1 if both actives are nonzero.
  - Later pix_ce cycles advance normally.
- RST mid-frame returns the generator to the reset state on the next edge; it does not finish the frame.
- frame_start implies line_start in the same cycle.
- Frame length = h_total × v_total pix_ce cycles.

## Test plan
- CGA cfg (912/640/704/768, 262/200/224/227), pix_ce=1, then release RST:
  - hs high for 64 pixels per line at x=704..767;
  - vs high for 3×912 cycles;
  - 640×200 active pixels per frame;
  - frame_start every 238944 cycles.
- pix_ce toggling 1/0:
  - frame period doubles to 477888 CLK cycles;
  - outputs are stable on ce=0 cycles;
  - no strobes on ce=0 cycles.
- Change cfg_h_total from 912 to 800 at mid-frame (y=100):
  - the current frame keeps 912;
  - line length is 800 starting from the frame_start that follows.
- cfg_h_sync_end=1000 > h_total=912 at a frame wrap:
  - cfg_err=1, outputs are inactive, and x=y=0;
  - after correcting to 768, the first pix_ce produces frame_start with cfg_err=0.
- H_POLARITY=0, V_POLARITY=0: after reset hs=vs=1; hs pulses low at x=704..767.
- Assert RST at x=300, y=50: on the next edge, x=y=0 and all outputs are at reset values; restart as in the startup rule.
